// File: rtl/raisin64_pkg.sv
// Shared definitions for the raisin64 data-memory path:
// FSM encoding and datapath widths.
package raisin64_pkg;

  localparam int XLEN  = 64;
  localparam int OFF_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    RECOVER = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage for dmem_responder:
// synchronous write, combinational read.
module dmem_array
  import raisin64_pkg::*;
#(
  parameter int WORDS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts strobed requests, inserts
// wait states, then completes with data or a bus error.
module dmem_responder
  import raisin64_pkg::*;
#(
  parameter int NUM_BYTES   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_dout,
  input  logic            dmem_rstrobe,
  input  logic            dmem_wstrobe,
  output logic [XLEN-1:0] dmem_din,
  output logic            dmem_cycle_complete,
  output logic            dmem_bus_error
);

  localparam int WORDS = NUM_BYTES / 8;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  dmem_state_t     state_q, state_d;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] addr_q, data_q;
  logic            wr_q;
  logic            accept, in_range, commit;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] rdata;

  assign idx      = addr_q[AW+OFF_W-1:OFF_W];
  assign in_range = addr_q < XLEN'(NUM_BYTES);
  assign commit   = (state_q == DONE) && wr_q
                  && in_range && !rst;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmem_rstrobe || dmem_wstrobe) begin
          accept  = 1'b1;
          state_d = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE:    state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cnt_q               <= 4'd0;
      dmem_cycle_complete <= 1'b0;
      dmem_bus_error      <= 1'b0;
      dmem_din            <= '0;
    end else begin
      state_q             <= state_d;
      dmem_cycle_complete <= (state_q == DONE);
      dmem_bus_error      <= (state_q == DONE) && !in_range;
      if (accept)
        cnt_q <= 4'(WAIT_STATES);
      else if (state_q == WAIT)
        cnt_q <= cnt_q - 4'd1;
      if (state_q == DONE && !wr_q)
        dmem_din <= in_range ? rdata : '0;
    end
  end

  // Write wins when both strobes are high.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= dmem_addr;
      data_q <= dmem_dout;
      wr_q   <= dmem_wstrobe;
    end
  end

  dmem_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (commit),
    .idx   (idx),
    .wdata (data_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with wait-state
// settings 2, 0 and 1 on three instances.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ad  [3];
  logic [63:0] dt  [3];
  logic [63:0] din [3];
  logic        rs  [3];
  logic        ws  [3];
  logic        cc  [3];
  logic        be  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.NUM_BYTES(256), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst),
    .dmem_addr(ad[2]), .dmem_dout(dt[2]),
    .dmem_rstrobe(rs[2]), .dmem_wstrobe(ws[2]),
    .dmem_din(din[2]),
    .dmem_cycle_complete(cc[2]),
    .dmem_bus_error(be[2])
  );

  dmem_responder #(.NUM_BYTES(256), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst),
    .dmem_addr(ad[0]), .dmem_dout(dt[0]),
    .dmem_rstrobe(rs[0]), .dmem_wstrobe(ws[0]),
    .dmem_din(din[0]),
    .dmem_cycle_complete(cc[0]),
    .dmem_bus_error(be[0])
  );

  dmem_responder #(.NUM_BYTES(256), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst),
    .dmem_addr(ad[1]), .dmem_dout(dt[1]),
    .dmem_rstrobe(rs[1]), .dmem_wstrobe(ws[1]),
    .dmem_din(din[1]),
    .dmem_cycle_complete(cc[1]),
    .dmem_bus_error(be[1])
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // One transaction; lat counts edges after the accept edge.
  task automatic xact(input int d, input bit w, input bit r,
                      input logic [63:0] a,
                      input logic [63:0] v,
                      output int lat,
                      output logic [63:0] rd,
                      output logic err);
    @(negedge clk);
    ad[d] = a; dt[d] = v; ws[d] = w; rs[d] = r;
    @(posedge clk); #1;
    ws[d] = 1'b0; rs[d] = 1'b0;
    lat = -1; rd = 'x; err = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (cc[d]) begin
        lat = n; rd = din[d]; err = be[d];
        break;
      end
    end
    if (lat < 0) begin
      chk("timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk); #1;
      chk("pulse_width", 64'(cc[d]), 64'd0);
    end
  endtask

  int          lat;
  logic [63:0] rd;
  logic        err;
  int          seen;
  int          t[$];

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ad[i] = '0; dt[i] = '0; rs[i] = 1'b0; ws[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_din", din[i], 64'd0);
      chk("rst_cc", 64'(cc[i]), 64'd0);
      chk("rst_be", 64'(be[i]), 64'd0);
    end
    @(negedge clk); rst = 1'b0;

    // WAIT_STATES=2: write then read back
    xact(2, 1, 0, 64'h10, 64'hDEADBEEF_CAFEF00D, lat, rd, err);
    chk("w10_lat", 64'(lat), 64'd3);
    chk("w10_err", 64'(err), 64'd0);
    chk("w10_din_hold", din[2], 64'd0);
    xact(2, 0, 1, 64'h10, 64'h0, lat, rd, err);
    chk("r10_lat", 64'(lat), 64'd3);
    chk("r10_data", rd, 64'hDEADBEEF_CAFEF00D);
    chk("r10_err", 64'(err), 64'd0);

    // out-of-range accesses
    xact(2, 1, 0, 64'h0, 64'h1234, lat, rd, err);
    xact(2, 0, 1, 64'h100, 64'h0, lat, rd, err);
    chk("r100_err", 64'(err), 64'd1);
    chk("r100_data", rd, 64'd0);
    chk("r100_lat", 64'(lat), 64'd3);
    xact(2, 1, 0, 64'h1_0000_0000, 64'hFF, lat, rd, err);
    chk("w_hi_err", 64'(err), 64'd1);
    xact(2, 0, 1, 64'h0, 64'h0, lat, rd, err);
    chk("r0_unchanged", rd, 64'h1234);
    chk("r0_err", 64'(err), 64'd0);

    // both strobes: write wins
    xact(2, 1, 1, 64'h8, 64'h55, lat, rd, err);
    chk("both_err", 64'(err), 64'd0);
    chk("both_din_hold", din[2], 64'h1234);
    xact(2, 0, 1, 64'h8, 64'h0, lat, rd, err);
    chk("r8_data", rd, 64'h55);

    // reset during WAIT abandons the write
    xact(2, 1, 0, 64'h20, 64'h77, lat, rd, err);
    @(negedge clk);
    ad[2] = 64'h20; dt[2] = 64'hAA; ws[2] = 1'b1;
    @(posedge clk); #1;
    ws[2] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_din", din[2], 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (cc[2]) seen++;
    end
    chk("rst_no_complete", 64'(seen), 64'd0);
    xact(2, 0, 1, 64'h20, 64'h0, lat, rd, err);
    chk("r20_prior", rd, 64'h77);

    // WAIT_STATES=0: offset bits ignored
    xact(0, 1, 0, 64'h10, 64'h1, lat, rd, err);
    chk("ws0_w_lat", 64'(lat), 64'd1);
    xact(0, 0, 1, 64'h17, 64'h0, lat, rd, err);
    chk("ws0_r_lat", 64'(lat), 64'd1);
    chk("ws0_r17", rd, 64'h1);
    chk("ws0_err", 64'(err), 64'd0);

    // WAIT_STATES=1: strobe held for three transactions
    @(negedge clk);
    ad[1] = 64'h18; dt[1] = 64'h9; ws[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (cc[1]) t.push_back(c);
      if (c == 10) ws[1] = 1'b0;
    end
    chk("burst_count", 64'(t.size()), 64'd3);
    if (t.size() == 3) begin
      chk("burst_first", 64'(t[0]), 64'd3);
      chk("burst_gap1", 64'(t[1] - t[0]), 64'd4);
      chk("burst_gap2", 64'(t[2] - t[1]), 64'd4);
    end
    xact(1, 0, 1, 64'h18, 64'h0, lat, rd, err);
    chk("ws1_r_lat", 64'(lat), 64'd2);
    chk("ws1_r18", rd, 64'h9);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 256, backing storage size in bytes; a multiple of 8.
REQ-002 SHALL have parameter WAIT_STATES, default 2, idle cycles inserted before completion; legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dmem_addr  input  64  byte address from the pipeline.
REQ-006 SHALL have port dmem_dout  input  64  write data from the pipeline.
REQ-007 SHALL have port dmem_rstrobe  input  1  read request, level.
REQ-008 SHALL have port dmem_wstrobe  input  1  write request, level.
REQ-009 SHALL have port dmem_din  output  64  read data to the pipeline.
REQ-010 SHALL have port dmem_cycle_complete  output  1  one-cycle completion pulse.
REQ-011 SHALL have port dmem_bus_error  output  1  one-cycle pulse, coincident with completion, for an out-of-range access.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT, DONE and RECOVER.
REQ-013 In IDLE with either strobe high, SHALL latch addr, dout and the request type, load the wait counter with WAIT_STATES, and go to WAIT; if WAIT_STATES=0, SHALL go directly to DONE.
REQ-014 When both strobes are high in the same cycle, the write SHALL take priority and the read SHALL be ignored.
REQ-015 In WAIT, SHALL decrement the counter each cycle and go to DONE on the cycle it reaches 0.
REQ-016 For WAIT_STATES=N, SHALL assert dmem_cycle_complete exactly N+1 cycles after the accept edge.
REQ-017 In DONE, SHALL assert dmem_cycle_complete for exactly one cycle and then go to RECOVER.
REQ-018 In RECOVER, SHALL ignore both strobes for one cycle and then return to IDLE; this gives the initiator one cycle to drop its strobe.
REQ-019 Strobes that drop while in WAIT SHALL NOT abort the transaction.
REQ-020 Word index SHALL be the latched addr[63:3]; addr[2:0] SHALL be ignored, with no sub-word or byte-lane access.
REQ-021 An access is in range iff the latched addr < NUM_BYTES, compared on the full 64 bits; there SHALL be no wrap-around or aliasing of high address bits.
REQ-022 In-range read: dmem_din SHALL present the stored word in the DONE cycle and hold it until the next DONE.
REQ-023 In-range write: the latched data SHALL be committed to storage on the DONE clock edge; dmem_din SHALL be unchanged.
REQ-024 Out-of-range access: dmem_bus_error SHALL pulse with dmem_cycle_complete; a read SHALL return 64'h0 and a write SHALL be dropped with storage unchanged.
REQ-025 A read of a word written by the immediately preceding transaction SHALL return the new data.
REQ-026 A new transaction SHALL be accepted at the earliest on the cycle after RECOVER; back-to-back throughput SHALL be one access per WAIT_STATES+3 cycles.

Reset
REQ-027 rst SHALL force the FSM to IDLE, the counter to 0, and dmem_cycle_complete, dmem_bus_error and dmem_din to 0.
REQ-028 rst asserted during WAIT SHALL abandon the transaction: no completion pulse and no write commit.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Requests present while rst is high SHALL be ignored; a strobe still high on the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-031 The FSM state encoding, the data width (64) and the byte-offset width (3) SHALL be defined in the shared package raisin64_pkg.
REQ-032 Storage SHALL be a sub-module dmem_array: single port, synchronous write, combinational read, NUM_BYTES/8 words.
REQ-033 The FSM, wait counter, range check and request latches SHALL be in dmem_responder.

Verification
REQ-034 WAIT_STATES=2: write 64'hDEADBEEF_CAFEF00D to addr 0x10, then read 0x10 -> completion 3 cycles after each accept; read returns the written data; bus_error=0.
REQ-035 WAIT_STATES=0: read of addr 0x17 after a write of 64'h1 to 0x10 -> returns 64'h1, the offset bits being ignored; completion 1 cycle after accept.
REQ-036 Read of addr 0x100 and write of 64'hFF to 0x1_0000_0000 with NUM_BYTES=256 -> bus_error pulses with completion; the read returns 0; word 0 is unchanged afterwards.
REQ-037 Both strobes high, addr 0x8, dout 64'h55 -> treated as a write; a subsequent read of 0x8 returns 64'h55.
REQ-038 rst pulsed during WAIT of a write of 64'hAA to 0x20 -> no completion pulse; a later read of 0x20 returns the prior contents.
REQ-039 Strobe held high continuously for 3 transactions with WAIT_STATES=1 -> completions spaced exactly 4 cycles apart; exactly one pulse per transaction.
